demux_1to4_reg: RTL and testbench
=================================

Name: demux_1to4_reg

Overview:
- Registered 1-to-4 demultiplexer.
- Routes the data input `enable` to exactly one of four outputs (result0..result3), chosen by the 2-bit select `sig`. All non-selected outputs are driven to zero.
- Sits as a small routing/fan-out stage between a single-source control/data line and four downstream consumers, in the single-clock domain.

Parameters:
- DATA_W, default 1: width of the `enable` data input and of each result output.
- REGISTERED, default 1: 1 = outputs registered (1-cycle latency); 0 = combinational path (reset has no effect on outputs).

Ports:
- clk  input  1  system clock; rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  DATA_W  data value to be routed.
- sig  input  2  select: 0 -> result0, 1 -> result1, 2 -> result2, 3 -> result3.
- result0  output  DATA_W  routed data when sig==0, else 0.
- result1  output  DATA_W  routed data when sig==1, else 0.
- result2  output  DATA_W  routed data when sig==2, else 0.
- result3  output  DATA_W  routed data when sig==3, else 0.

Behaviour:
- One clock, clk. Reset rst_n is asynchronous and active-low: assertion takes effect immediately, and deassertion is sampled on the clock.
- Reset (REGISTERED=1): while rst_n==0, result0..result3 = 0 immediately, independent of clk.
- Decode: sig is decoded to a 4-bit one-hot vector sel[3:0], with sel[i]=1 iff sig==i.
- Next-state per output i: next_result_i = sel[i] ? enable : {DATA_W{1'b0}}. Bitwise AND of enable with the replicated sel[i].
- REGISTERED=1:
  - result_i takes next_result_i on each rising clk edge with rst_n high.
  - Latency is exactly 1 cycle from sig/enable change to output.
  - There is no hold or clock-enable; outputs update every cycle.
- REGISTERED=0:
  - result_i = next_result_i combinationally.
  - Zero latency; clk and rst_n are unused.
- Exactly one output can be nonzero at any time. All four are zero when enable==0 or during reset.
- sig containing X/Z: not a legal operating condition. The implementation drives all outputs to 0 via the decoder default branch.
- Select change between edges: only the value sampled at the edge matters. There are no glitches on registered outputs.
- Reset mid-operation: outputs clear immediately. The first rising edge after deassertion loads the currently selected routing.
- No internal state beyond the four output registers.

Decomposition:
- Package demux_pkg:
  - localparam NUM_OUT = 4, SEL_W = 2.
  - Select encodings SEL_R0=2'd0, SEL_R1=2'd1, SEL_R2=2'd2, SEL_R3=2'd3.
- Sub-module demux_sel_decode:
  - Pure combinational 2-to-4 one-hot decoder (sig -> sel[3:0]).
  - Default branch yields 4'b0000.
  - Instantiated once.
- Top level: per-output masking and a generate block choosing registered vs combinational output per REGISTERED.

Test Plan:
- Reset: hold rst_n=0 with enable=1, sig=2 across several clk edges. Required: result0..3 = 0 throughout. After release, the next edge gives result2=1 and the others 0.
- Select sweep (DATA_W=1, REGISTERED=1): enable=1, sig=0,1,2,3, each held 2 cycles. Required: one cycle after each change, only result{sig}=1 (result0, then result1, result2, result3); all others 0.
- Data gating: enable=0 with sig=0..3. Required: all outputs 0 at every step.
- Async reset mid-stream: with enable=1, sig=3, result3=1, pulse rst_n low between clock edges. Required: result3 drops to 0 immediately, not at the next edge.
- Wide data (DATA_W=8): enable=8'hA5, sig=1. Required: result1=8'hA5 and result0/2/3=8'h00 one cycle later. Then sig=2 gives result2=8'hA5 and result1=8'h00.
- Combinational mode (REGISTERED=0): enable=1, sig stepping 0->3 every 20 time units. Required: outputs follow within the same timestep, with result{sig}=1 and all others 0.

Source files
------------

// File: rtl/demux_pkg.sv
// demux_pkg: shared constants for the registered 1-to-4 demultiplexer.
//   NUM_OUT  - number of routed outputs
//   SEL_W    - width of the output select
//   SEL_R0..SEL_R3 - select encodings, one per output
package demux_pkg;

  localparam int NUM_OUT = 4;
  localparam int SEL_W   = 2;

  localparam logic [SEL_W-1:0] SEL_R0 = 2'd0;
  localparam logic [SEL_W-1:0] SEL_R1 = 2'd1;
  localparam logic [SEL_W-1:0] SEL_R2 = 2'd2;
  localparam logic [SEL_W-1:0] SEL_R3 = 2'd3;

endpackage : demux_pkg

// File: rtl/demux_sel_decode.sv
// demux_sel_decode: combinational 2-to-4 one-hot decoder.
// Ports:
//   sig  in  [SEL_W-1:0]    select code
//   sel  out [NUM_OUT-1:0]  one-hot select, sel[i]=1 iff sig==i
// Any code outside the legal set (X/Z in simulation) decodes to all-zero,
// so no output is routed.
module demux_sel_decode
  import demux_pkg::*;
(
  input  logic [SEL_W-1:0]   sig,
  output logic [NUM_OUT-1:0] sel
);

  always_comb begin
    sel = '0;
    case (sig)
      SEL_R0:  sel = 4'b0001;
      SEL_R1:  sel = 4'b0010;
      SEL_R2:  sel = 4'b0100;
      SEL_R3:  sel = 4'b1000;
      default: sel = 4'b0000;
    endcase
  end

endmodule : demux_sel_decode

// File: rtl/demux_1to4_reg.sv
// demux_1to4_reg: 1-to-4 demultiplexer with optional output register.
// Routes enable to the output chosen by sig; all other outputs are zero.
// Parameters:
//   DATA_W     - width of enable and of each result
//   REGISTERED - 1: outputs registered (1-cycle latency, async active-low
//                reset clears them); 0: combinational, clk/rst_n unused
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   enable   in   [DATA_W-1:0] data to route
//   sig      in   [1:0] select: 0..3 -> result0..result3
//   result0..result3 out [DATA_W-1:0] routed data or zero
module demux_1to4_reg
  import demux_pkg::*;
#(
  parameter int DATA_W     = 1,
  parameter bit REGISTERED = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] enable,
  input  logic [1:0]        sig,
  output logic [DATA_W-1:0] result0,
  output logic [DATA_W-1:0] result1,
  output logic [DATA_W-1:0] result2,
  output logic [DATA_W-1:0] result3
);

  logic [NUM_OUT-1:0] sel;
  logic [DATA_W-1:0]  next_result [NUM_OUT];
  logic [DATA_W-1:0]  result      [NUM_OUT];

  demux_sel_decode u_decode (
    .sig (sig),
    .sel (sel)
  );

  // Each output sees enable masked by its own one-hot select bit.
  for (genvar i = 0; i < NUM_OUT; i++) begin : g_mask
    assign next_result[i] = enable & {DATA_W{sel[i]}};
  end

  if (REGISTERED) begin : g_reg
    // Outputs reload every cycle; there is no hold/enable.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < NUM_OUT; i++) begin
          result[i] <= '0;
        end
      end else begin
        for (int i = 0; i < NUM_OUT; i++) begin
          result[i] <= next_result[i];
        end
      end
    end
  end else begin : g_comb
    for (genvar i = 0; i < NUM_OUT; i++) begin : g_pass
      assign result[i] = next_result[i];
    end
  end

  assign result0 = result[0];
  assign result1 = result[1];
  assign result2 = result[2];
  assign result3 = result[3];

endmodule : demux_1to4_reg

// File: tb/tb_demux_1to4_reg.sv
// tb_demux_1to4_reg: exercises a 1-bit registered instance, an 8-bit
// registered instance and a 1-bit combinational instance.
module tb_demux_1to4_reg;

  logic clk;
  logic rst_n;

  // 1-bit registered instance
  logic       n_en;
  logic [1:0] n_sig;
  logic       n_r0, n_r1, n_r2, n_r3;

  // 8-bit registered instance
  logic [7:0] w_en;
  logic [1:0] w_sig;
  logic [7:0] w_r0, w_r1, w_r2, w_r3;

  // 1-bit combinational instance
  logic       c_en;
  logic [1:0] c_sig;
  logic       c_r0, c_r1, c_r2, c_r3;

  int n_checks = 0;
  int n_fail   = 0;

  // Each entry: {narrow expected [35:32], wide expected [31:0]}
  logic [35:0] exp_q[$];

  demux_1to4_reg #(.DATA_W(1), .REGISTERED(1'b1)) dut_n (
    .clk (clk), .rst_n (rst_n), .enable (n_en), .sig (n_sig),
    .result0 (n_r0), .result1 (n_r1), .result2 (n_r2), .result3 (n_r3)
  );

  demux_1to4_reg #(.DATA_W(8), .REGISTERED(1'b1)) dut_w (
    .clk (clk), .rst_n (rst_n), .enable (w_en), .sig (w_sig),
    .result0 (w_r0), .result1 (w_r1), .result2 (w_r2), .result3 (w_r3)
  );

  demux_1to4_reg #(.DATA_W(1), .REGISTERED(1'b0)) dut_c (
    .clk (clk), .rst_n (rst_n), .enable (c_en), .sig (c_sig),
    .result0 (c_r0), .result1 (c_r1), .result2 (c_r2), .result3 (c_r3)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  function automatic logic [3:0] model_n(logic en, logic [1:0] s);
    case (s)
      2'd0:    return {3'b000, en};
      2'd1:    return {2'b00, en, 1'b0};
      2'd2:    return {1'b0, en, 2'b00};
      default: return {en, 3'b000};
    endcase
  endfunction

  function automatic logic [31:0] model_w(logic [7:0] en, logic [1:0] s);
    case (s)
      2'd0:    return {24'h0, en};
      2'd1:    return {16'h0, en, 8'h0};
      2'd2:    return {8'h0, en, 16'h0};
      default: return {en, 24'h0};
    endcase
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] obs_n();
    return {28'h0, n_r3, n_r2, n_r1, n_r0};
  endfunction

  function automatic logic [31:0] obs_w();
    return {w_r3, w_r2, w_r1, w_r0};
  endfunction

  function automatic logic [31:0] obs_c();
    return {28'h0, c_r3, c_r2, c_r1, c_r0};
  endfunction

  // ---------------- driver ----------------
  // Drive on the falling edge, expect the result after the next rising edge.
  task automatic step(input string tag, input logic ne, input logic [1:0] ns,
                      input logic [7:0] we, input logic [1:0] ws);
    logic [35:0] e;
    @(negedge clk);
    n_en  = ne;
    n_sig = ns;
    w_en  = we;
    w_sig = ws;
    exp_q.push_back({model_n(ne, ns), model_w(we, ws)});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_n"}, obs_n(), {28'h0, e[35:32]});
      check({tag, "_w"}, obs_w(), e[31:0]);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    n_en  = 1'b1;  n_sig = 2'd2;
    w_en  = 8'hff; w_sig = 2'd2;
    c_en  = 1'b0;  c_sig = 2'd0;

    // Reset held across several edges: outputs stay zero.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_n", obs_n(), 32'h0);
      check("reset_w", obs_w(), 32'h0);
    end

    // Release between edges; the next edge loads the sig=2 routing.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_n", obs_n(), 32'h4);
    check("post_reset_w", obs_w(), 32'h00ff_0000);

    // Select sweep, each held two cycles.
    for (int s = 0; s < 4; s++) begin
      step("sweep", 1'b1, 2'(s), 8'h3c, 2'(s));
      step("sweep_hold", 1'b1, 2'(s), 8'h3c, 2'(s));
    end

    // Data gating: enable=0 yields all zeros.
    for (int s = 0; s < 4; s++) begin
      step("gate", 1'b0, 2'(s), 8'h00, 2'(s));
    end

    // Wide data routing.
    step("wide_s1", 1'b1, 2'd1, 8'ha5, 2'd1);
    step("wide_s2", 1'b1, 2'd2, 8'ha5, 2'd2);

    // Async reset pulse between edges with result3 active.
    step("pre_async", 1'b1, 2'd3, 8'h5a, 2'd3);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_n", obs_n(), 32'h0);
    check("async_w", obs_w(), 32'h0);
    #1;
    rst_n = 1'b1;
    // First edge after release reloads the current routing.
    @(posedge clk);
    #1;
    check("async_reload_n", obs_n(), 32'h8);
    check("async_reload_w", obs_w(), 32'h5a00_0000);

    // Random traffic.
    for (int i = 0; i < 24; i++) begin
      step("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));
    end

    // Combinational instance: outputs follow inputs without a clock.
    c_en = 1'b1;
    for (int s = 0; s < 4; s++) begin
      c_sig = 2'(s);
      #1;
      check("comb", obs_c(), {28'h0, model_n(1'b1, 2'(s))});
      #19;
    end
    c_en = 1'b0;
    #1;
    check("comb_gate", obs_c(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule : tb_demux_1to4_reg
